// File: rtl/pc_sequencer_if.sv
// Fetch-stage control and status bundle between the pipeline and pc_sequencer.
// The master drives redirect requests; the slave (the sequencer) returns
// the registered fetch address and status.
interface pc_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             int_req;
    logic             jmp;
    logic             call;
    logic             ret;
    logic             jwsp;
    logic [WIDTH-1:0] jmp_dst;
    logic [WIDTH-1:0] acc_pc;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] epc;
    logic             halted;
    logic             ras_overflow;
    logic             ras_underflow;

    modport master (
        output stall, int_req, jmp, call, ret, jwsp, jmp_dst, acc_pc,
        input  pc_out, epc, halted, ras_overflow, ras_underflow
    );

    modport slave (
        input  stall, int_req, jmp, call, ret, jwsp, jmp_dst, acc_pc,
        output pc_out, epc, halted, ras_overflow, ras_underflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: selects the next fetch address from reset,
// interrupt, stall, call/jmp/ret, accumulated PC and increment sources, with
// a return-address stack, exception PC and a halt state at PC_LIMIT.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RUN  | PC advancing or just redirected
// ST_HALT | PC parked at PC_LIMIT; any redirect returns to ST_RUN
module pc_sequencer #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32),
    parameter logic [WIDTH-1:0] INT_VEC   = WIDTH'(0),
    parameter logic [WIDTH-1:0] PC_LIMIT  = WIDTH'(50),
    parameter int               RAS_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int SP_W = $clog2(RAS_DEPTH + 1);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_pc, w_pc_nxt;
    logic [WIDTH-1:0] r_epc, w_epc_nxt;
    logic [SP_W-1:0]  r_sp, w_sp_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic             r_unf, w_unf_nxt;
    logic [WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [WIDTH-1:0] w_top;
    logic             w_push;
    logic             w_full;
    logic             w_empty;

    assign w_full  = (r_sp == SP_W'(RAS_DEPTH));
    assign w_empty = (r_sp == '0);

    // Top-of-stack read; the entry below the pointer is the most recent push.
    always_comb begin
        w_top = '0;
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (r_sp == SP_W'(i + 1)) w_top = r_stack[i];
        end
    end

    // Next-state selection in strict priority: interrupt, stall, call, jmp, ret, jwsp, increment.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_epc_nxt   = r_epc;
        w_sp_nxt    = r_sp;
        w_ovf_nxt   = r_ovf;
        w_unf_nxt   = r_unf;
        w_push      = 1'b0;
        if (bus.int_req) begin
            w_epc_nxt   = r_pc;
            w_pc_nxt    = INT_VEC;
            w_state_nxt = ST_RUN;
        end else if (bus.stall) begin
            w_state_nxt = r_state;
        end else if (bus.call) begin
            w_pc_nxt    = bus.jmp_dst;
            w_state_nxt = ST_RUN;
            if (w_full) begin
                w_ovf_nxt = 1'b1;
            end else begin
                w_push   = 1'b1;
                w_sp_nxt = r_sp + SP_W'(1);
            end
        end else if (bus.jmp) begin
            w_pc_nxt    = bus.jmp_dst;
            w_state_nxt = ST_RUN;
        end else if (bus.ret) begin
            if (w_empty) begin
                w_unf_nxt = 1'b1;
            end else begin
                w_pc_nxt    = w_top;
                w_sp_nxt    = r_sp - SP_W'(1);
                w_state_nxt = ST_RUN;
            end
        end else if (bus.jwsp) begin
            w_pc_nxt    = bus.acc_pc;
            w_state_nxt = ST_RUN;
        end else if (r_pc < PC_LIMIT) begin
            w_pc_nxt    = r_pc + WIDTH'(1);
            w_state_nxt = ST_RUN;
        end else begin
            w_state_nxt = ST_HALT;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_VEC;
            r_epc   <= '0;
            r_sp    <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_epc   <= w_epc_nxt;
            r_sp    <= w_sp_nxt;
            r_ovf   <= w_ovf_nxt;
            r_unf   <= w_unf_nxt;
        end
    end

    // Stack storage needs no reset; only the pointer defines valid entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < RAS_DEPTH; i++) begin
            if (!reset && w_push && r_sp == SP_W'(i)) r_stack[i] <= r_pc + WIDTH'(1);
        end
    end

    assign bus.pc_out        = r_pc;
    assign bus.epc           = r_epc;
    assign bus.halted        = (r_state == ST_HALT);
    assign bus.ras_overflow  = r_ovf;
    assign bus.ras_underflow = r_unf;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    logic clk;
    logic rst_x32;
    logic rst_x16;
    int   vectors;
    int   miscompares;

    pc_sequencer_if #(.WIDTH(32)) ifa ();
    pc_sequencer_if #(.WIDTH(16)) ifb ();

    pc_sequencer dut_a (
        .clk   (clk),
        .reset (rst_x32),
        .bus   (ifa.slave)
    );

    pc_sequencer #(
        .WIDTH     (16),
        .RESET_VEC (16'h0000),
        .INT_VEC   (16'h0000),
        .PC_LIMIT  (16'hFFFF),
        .RAS_DEPTH (4)
    ) dut_b (
        .clk   (clk),
        .reset (rst_x16),
        .bus   (ifb.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model for the default-parameter instance
    logic [31:0] m_pc, m_epc;
    logic        m_halt, m_ovf, m_unf;
    logic [31:0] m_stack [$];

    typedef struct {
        logic        rst, st, ir, j, c, r, w;
        logic [31:0] dst, acc;
        logic [31:0] e_pc, e_epc;
        logic        e_halt, e_ovf, e_unf;
    } vec_t;

    vec_t tbl [$];

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(logic rst, logic st, logic ir, logic j, logic c,
                              logic r, logic w, logic [31:0] dst, logic [31:0] acc);
        if (rst) begin
            m_pc = 32; m_epc = 0; m_halt = 0; m_ovf = 0; m_unf = 0;
            m_stack.delete();
        end else if (ir) begin
            m_epc = m_pc; m_pc = 0; m_halt = 0;
        end else if (st) begin
            m_pc = m_pc;
        end else if (c) begin
            if (m_stack.size() == 4) m_ovf = 1;
            else m_stack.push_back(m_pc + 32'd1);
            m_pc = dst; m_halt = 0;
        end else if (j) begin
            m_pc = dst; m_halt = 0;
        end else if (r) begin
            if (m_stack.size() > 0) begin
                m_pc = m_stack.pop_back(); m_halt = 0;
            end else m_unf = 1;
        end else if (w) begin
            m_pc = acc; m_halt = 0;
        end else if (m_pc < 32'd50) begin
            m_pc = m_pc + 32'd1; m_halt = 0;
        end else m_halt = 1;
    endtask

    task automatic cyc(string nm, logic rst, logic st, logic ir, logic j, logic c,
                       logic r, logic w, logic [31:0] dst, logic [31:0] acc);
        rst_x32 = rst; ifa.stall = st; ifa.int_req = ir; ifa.jmp = j;
        ifa.call = c; ifa.ret = r; ifa.jwsp = w; ifa.jmp_dst = dst; ifa.acc_pc = acc;
        model_step(rst, st, ir, j, c, r, w, dst, acc);
        @(posedge clk); #1;
        check({nm, ".pc"},  ifa.pc_out, m_pc);
        check({nm, ".epc"}, ifa.epc, m_epc);
        check({nm, ".halted"}, 32'(ifa.halted), 32'(m_halt));
        check({nm, ".ovf"}, 32'(ifa.ras_overflow), 32'(m_ovf));
        check({nm, ".unf"}, 32'(ifa.ras_underflow), 32'(m_unf));
    endtask

    task automatic cycb(string nm, logic rst, logic j, logic c, logic r,
                        logic [15:0] dst, logic [15:0] e_pc, logic e_halt);
        rst_x16 = rst; ifb.jmp = j; ifb.call = c; ifb.ret = r; ifb.jmp_dst = dst;
        @(posedge clk); #1;
        check({nm, ".pc16"}, 32'(ifb.pc_out), 32'(e_pc));
        check({nm, ".halted16"}, 32'(ifb.halted), 32'(e_halt));
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst_x32 = 1; rst_x16 = 1;
        ifa.stall = 0; ifa.int_req = 0; ifa.jmp = 0; ifa.call = 0; ifa.ret = 0;
        ifa.jwsp = 0; ifa.jmp_dst = 0; ifa.acc_pc = 0;
        ifb.stall = 0; ifb.int_req = 0; ifb.jmp = 0; ifb.call = 0; ifb.ret = 0;
        ifb.jwsp = 0; ifb.jmp_dst = 0; ifb.acc_pc = 0;
        m_pc = 0; m_epc = 0; m_halt = 0; m_ovf = 0; m_unf = 0;

        //                 rst st ir j  c  r  w  dst acc  pc  epc h ovf unf
        tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0,  0,  32, 0,  0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  0,  33, 0,  0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 5,  0,  5,  0,  0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  0,  6,  0,  0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 0, 20, 0,  20, 0,  0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0,  0,  7,  0,  0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0,  0,  34, 0,  0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0,  0,  34, 0,  0, 0, 1});
        tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 10, 0,  10, 0,  0, 0, 1});
        tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 40, 0,  40, 0,  0, 0, 1});
        tbl.push_back('{0, 1, 1, 0, 0, 0, 0, 0,  0,  0,  40, 0, 0, 1});
        tbl.push_back('{0, 1, 0, 1, 0, 0, 0, 9,  0,  0,  40, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1, 0,  48, 48, 40, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  0,  49, 40, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  0,  50, 40, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  0,  50, 40, 1, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  0,  50, 40, 1, 0, 1});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 0, 0,  0,  50, 40, 1, 0, 1});
        tbl.push_back('{0, 0, 0, 1, 0, 0, 0, 10, 0,  10, 40, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 1, 1, 1, 1, 7,  9,  7,  40, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0,  0,  11, 40, 0, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 0, 0,  0,  11, 40, 0, 0, 1});
        tbl.push_back('{0, 0, 1, 0, 0, 0, 0, 0,  0,  0,  11, 0, 0, 1});
        tbl.push_back('{1, 1, 1, 0, 0, 0, 0, 0,  0,  32, 0,  0, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 0, 0,  0,  33, 0,  0, 0, 0});

        @(posedge clk); #1;
        foreach (tbl[k]) begin
            cyc($sformatf("tbl%0d", k), tbl[k].rst, tbl[k].st, tbl[k].ir, tbl[k].j,
                tbl[k].c, tbl[k].r, tbl[k].w, tbl[k].dst, tbl[k].acc);
            check($sformatf("tbl%0d.pc_fixed", k), ifa.pc_out, tbl[k].e_pc);
            check($sformatf("tbl%0d.epc_fixed", k), ifa.epc, tbl[k].e_epc);
            check($sformatf("tbl%0d.st_fixed", k),
                  {29'd0, ifa.halted, ifa.ras_overflow, ifa.ras_underflow},
                  {29'd0, tbl[k].e_halt, tbl[k].e_ovf, tbl[k].e_unf});
        end

        // Overflow: five calls from reset, fifth discarded, then LIFO unwind
        cyc("ovf_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) cyc("ovf_call", 0, 0, 0, 0, 1, 0, 0, 32'(k * 100), 0);
        check("ovf_flag", 32'(ifa.ras_overflow), 32'd1);
        check("ovf_pc", ifa.pc_out, 32'd500);
        cyc("ovf_ret1", 0, 0, 0, 0, 0, 1, 0, 0, 0); check("ovf_lifo1", ifa.pc_out, 32'd301);
        cyc("ovf_ret2", 0, 0, 0, 0, 0, 1, 0, 0, 0); check("ovf_lifo2", ifa.pc_out, 32'd201);
        cyc("ovf_ret3", 0, 0, 0, 0, 0, 1, 0, 0, 0); check("ovf_lifo3", ifa.pc_out, 32'd101);
        cyc("ovf_ret4", 0, 0, 0, 0, 0, 1, 0, 0, 0); check("ovf_lifo4", ifa.pc_out, 32'd33);
        cyc("ovf_ret5", 0, 0, 0, 0, 0, 1, 0, 0, 0); check("ovf_unf", 32'(ifa.ras_underflow), 32'd1);

        // Randomized traffic against the model
        cyc("rnd_rst", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] d, a;
            d = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 60));
            a = ($urandom_range(0, 15) == 0) ? $urandom() : 32'($urandom_range(0, 60));
            cyc("rnd", $urandom_range(0, 99) == 0, $urandom_range(0, 5) == 0,
                $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                $urandom_range(0, 9) == 0, d, a);
        end

        // 16-bit instance: wrap of the pushed return address and free-run
        cycb("w16_rst",  1, 0, 0, 0, 16'h0000, 16'h0000, 0);
        cycb("w16_run1", 0, 0, 0, 0, 16'h0000, 16'h0001, 0);
        cycb("w16_run2", 0, 0, 0, 0, 16'h0000, 16'h0002, 0);
        cycb("w16_jmp",  0, 1, 0, 0, 16'hFFFF, 16'hFFFF, 0);
        cycb("w16_halt", 0, 0, 0, 0, 16'h0000, 16'hFFFF, 1);
        cycb("w16_call", 0, 0, 1, 0, 16'h0005, 16'h0005, 0);
        cycb("w16_ret",  0, 0, 0, 1, 16'h0000, 16'h0000, 0);
        cycb("w16_run3", 0, 0, 0, 0, 16'h0000, 16'h0001, 0);
        cycb("w16_jmp2", 0, 1, 0, 0, 16'hFFFE, 16'hFFFE, 0);
        cycb("w16_lim",  0, 0, 0, 0, 16'h0000, 16'hFFFF, 0);
        cycb("w16_hold", 0, 0, 0, 0, 16'h0000, 16'hFFFF, 1);
        check("w16_ovf", 32'(ifb.ras_overflow), 32'd0);
        check("w16_unf", 32'(ifb.ras_underflow), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised fetch-stage program counter that replaces the fixed 32-bit PC. It selects the next fetch address each cycle from reset, interrupt, stall, jump, call/return and accumulated-PC (JWSP) sources. It adds an on-chip return-address stack, an exception PC (EPC) register and an explicit halt state at a programmable upper address bound. It sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
Parameters:
- WIDTH, 32, PC / address width in bits
- RESET_VEC, 32, PC value loaded on reset
- INT_VEC, 0, PC value loaded on interrupt
- PC_LIMIT, 50, increment bound; PC never increments past this value
- RAS_DEPTH, 4, return-address stack entries (≥1)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard stall; freezes all state
- int_req  in  1  interrupt request
- jmp  in  1  unconditional jump to jmp_dst
- call  in  1  jump to jmp_dst and push return address
- ret  in  1  pop return-address stack into PC
- jwsp  in  1  load acc_pc
- jmp_dst  in  WIDTH  jump/call target
- acc_pc  in  WIDTH  accumulated PC for JWSP
- pc_out  out  WIDTH  current fetch address (registered)
- epc  out  WIDTH  PC saved at last interrupt (registered)
- halted  out  1  PC parked at PC_LIMIT (registered)
- ras_overflow  out  1  sticky: call issued with stack full
- ras_underflow  out  1  sticky: ret issued with stack empty

## Operation
- Reset values: pc_out=RESET_VEC, epc=0, halted=0, ras_overflow=0, ras_underflow=0, stack pointer=0 (empty), stack contents don't-care.
- One action per edge, strict priority:
  1. reset
  2. int_req
  3. stall
  4. call
  5. jmp
  6. ret
  7. jwsp
  8. default increment
- int_req: epc←pc_out, pc_out←INT_VEC, halted←0. The stack is unchanged. Wins over stall.
- stall: all registers hold, including stack, epc, halted and sticky flags.
- call (wins over simultaneous jmp): push (pc_out+1) mod 2^WIDTH, pc_out←jmp_dst, halted←0.
  - Stack full: push discarded, stack unchanged, ras_overflow←1; the jump still happens.
- jmp: pc_out←jmp_dst, halted←0.
- ret:
  - Stack non-empty: pc_out←top, pop, halted←0.
  - Stack empty: pc_out holds, ras_underflow←1, halted unchanged.
- jwsp: pc_out←acc_pc, halted←0.
- Default:
  - pc_out < PC_LIMIT: pc_out←pc_out+1, halted←0.
  - Otherwise: pc_out holds, halted←1.
- Stack is LIFO, depth RAS_DEPTH, pointer width ceil(log2(RAS_DEPTH+1)). Full = RAS_DEPTH entries; empty = 0.
- Sticky flags clear only on reset.
- halted is not a lock: any redirect (int, call, jmp, successful ret, jwsp) leaves HALT.
- All comparisons are unsigned, WIDTH bits.

## Timing
- Every output is registered. A request sampled at edge N is visible on pc_out after edge N (zero-bubble redirect).
- A pushed return address is available to a ret on the very next cycle.
- Reset asserted mid-stall or mid-interrupt wins at that edge. pc_out=RESET_VEC on the following cycle.
- No combinational path from inputs to outputs.

## Test plan
- Reset then free-run:
  - pc_out=32, 33, …, 50; then holds 50 with halted=1 from the edge after reaching 50.
  - jmp_dst=10 with jmp=1 → pc_out=10, halted=0.
- Interrupt during stall: pc_out=40, stall=1, int_req=1 → pc_out=0 (INT_VEC), epc=40.
- Call/ret nesting:
  - call to 5 at pc 33 → pc 5; call to 20 at pc 6 → pc 20.
  - ret → pc 7; ret → pc 34; a third ret → pc holds, ras_underflow=1.
- Overflow (RAS_DEPTH=4): five consecutive calls → fifth jumps but ras_overflow=1. Four rets return the first four addresses in LIFO order.
- Priority:
  - call=1, jmp=1, ret=1, jwsp=1 same cycle → call taken, one push.
  - stall=1 with jmp=1 → pc_out and stack unchanged.
- Parameter sweep: WIDTH=16, RESET_VEC=0, PC_LIMIT=16'hFFFF, call at pc 16'hFFFF → pushed return address 0 (wrap). Repeat the free-run scenario.
